// File: rtl/add1_seq_ctrl_if.sv
// Handshake bundle between the two requesters, the sequencer and the
// bit-serial incrementer. The controller uses the slave modport.
interface add1_seq_ctrl_if #(parameter int NUMBITS = 4);
  logic               req0_valid;
  logic               req1_valid;
  logic [NUMBITS-1:0] req0_data;
  logic [NUMBITS-1:0] req1_data;
  logic               req0_ready;
  logic               req1_ready;

  logic               rsp0_valid;
  logic               rsp1_valid;
  logic               rsp0_ready;
  logic               rsp1_ready;
  logic [NUMBITS-1:0] rsp0_data;
  logic [NUMBITS-1:0] rsp1_data;
  logic               rsp0_ovf;
  logic               rsp1_ovf;

  logic               add_reset;
  logic               add_in;
  logic               add_out;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_ovf, rsp1_ovf,
    output rsp0_ready, rsp1_ready,
    input  add_reset, add_in,
    output add_out
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, rsp0_ovf, rsp1_ovf,
    input  rsp0_ready, rsp1_ready,
    output add_reset, add_in,
    input  add_out
  );
endinterface

// File: rtl/add1_seq_ctrl.sv
// Round-robin sequencer for the shared bit-serial incrementer: accepts an
// operand, clears the incrementer, streams bits LSB-first, returns the result.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept one operand
// CLR   | one-cycle clear pulse to the incrementer (carry <= 1)
// SHIFT | stream op_reg[k] out, capture add_out into res_reg[k]
// RESP  | hold result for the owner until it is taken
module add1_seq_ctrl #(
  parameter int NUMBITS = 4
) (
  input logic          clk,
  input logic          reset,
  add1_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, RESP} state_t;

  localparam int KW = (NUMBITS > 2) ? $clog2(NUMBITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUMBITS - 1);

  state_t             state;
  state_t             state_nxt;
  logic [KW-1:0]      k;
  logic [NUMBITS-1:0] op_reg;
  logic [NUMBITS-1:0] res_reg;
  logic               owner;
  logic               last_grant;
  logic               ovf_reg;

  logic               any_valid;
  logic               grant;
  logic [NUMBITS-1:0] grant_data;
  logic               accept;
  logic               rsp_take;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant = ~last_grant;
    else
      grant = bus.req1_valid;
    grant_data = grant ? bus.req1_data : bus.req0_data;
    accept     = (state == IDLE) && any_valid;
    rsp_take   = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLR;
      CLR:     state_nxt = SHIFT;
      SHIFT:   if (k == K_LAST) state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k          <= '0;
      op_reg     <= '0;
      res_reg    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ovf_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg     <= grant_data;
        owner      <= grant;
        last_grant <= grant;
        ovf_reg    <= &grant_data;
        k          <= '0;
      end
      if (state == SHIFT) begin
        res_reg[k] <= bus.add_out;
        k          <= (k == K_LAST) ? '0 : k + 1'b1;
      end
    end
  end

  // Response outputs read zero unless the owner is being served.
  always_comb begin
    bus.req0_ready = accept && !grant;
    bus.req1_ready = accept && grant;
    bus.rsp0_valid = (state == RESP) && !owner;
    bus.rsp1_valid = (state == RESP) && owner;
    bus.rsp0_data  = bus.rsp0_valid ? res_reg : '0;
    bus.rsp1_data  = bus.rsp1_valid ? res_reg : '0;
    bus.rsp0_ovf   = bus.rsp0_valid && ovf_reg;
    bus.rsp1_ovf   = bus.rsp1_valid && ovf_reg;
    bus.add_reset  = (state == CLR);
    bus.add_in     = (state == SHIFT) ? op_reg[k] : 1'b0;
  end

endmodule

// File: tb/tb_add1_seq_ctrl.sv
// Scoreboard bench for add1_seq_ctrl with a behavioural serial incrementer
// and a cycle-level model of arbitration and latency.
module tb_add1_seq_ctrl;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  add1_seq_ctrl_if #(.NUMBITS(NB)) bif ();

  add1_seq_ctrl #(.NUMBITS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  // Behavioural incrementer.
  logic carry = 1'b0;
  always @(posedge clk)
    carry <= bif.add_reset ? 1'b1 : (bif.add_in & carry);
  assign bif.add_out = bif.add_in ^ carry;

  typedef struct {
    logic [NB-1:0] data;
    logic          ovf;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Back-pressure driver: 0 = always ready, 1 = random, 2 = manual.
  int   mode = 0;
  logic man0 = 1'b1;
  logic man1 = 1'b1;
  always @(posedge clk or posedge reset) begin
    #1;
    if (mode == 0) begin
      bif.rsp0_ready = 1'b1;
      bif.rsp1_ready = 1'b1;
    end else if (mode == 1) begin
      bif.rsp0_ready = 1'($urandom_range(0, 1));
      bif.rsp1_ready = 1'($urandom_range(0, 1));
    end else begin
      bif.rsp0_ready = man0;
      bif.rsp1_ready = man1;
    end
  end

  // Reference timing model: busy for CLR + NB shift cycles, then in response.
  logic m_busy, m_owner, m_lg, mg;
  int   m_cnt;
  assign mg = (bif.req0_valid && bif.req1_valid) ? !m_lg : bif.req1_valid;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_owner <= 1'b0; m_lg <= 1'b1;
    end else if (!m_busy) begin
      if (bif.req0_valid || bif.req1_valid) begin
        m_busy <= 1'b1; m_cnt <= 0; m_owner <= mg; m_lg <= mg;
      end
    end else if (m_cnt < NB + 1) begin
      m_cnt <= m_cnt + 1;
    end else if (m_owner ? bif.rsp1_ready : bif.rsp0_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Monitor: protocol checks against the model plus scoreboard pops.
  always @(negedge clk) begin
    if (!reset) begin
      chk("req0_ready", bif.req0_ready, !m_busy && bif.req0_valid && !mg);
      chk("req1_ready", bif.req1_ready, !m_busy && bif.req1_valid && mg);
      chk("rsp0_valid", bif.rsp0_valid, m_busy && m_cnt == NB + 1 && !m_owner);
      chk("rsp1_valid", bif.rsp1_valid, m_busy && m_cnt == NB + 1 && m_owner);
      chk("add_reset", bif.add_reset, m_busy && m_cnt == 0);
      if (bif.rsp0_valid) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          chk("rsp0_data", bif.rsp0_data, q0[0].data);
          chk("rsp0_ovf", bif.rsp0_ovf, q0[0].ovf);
          if (bif.rsp0_ready) void'(q0.pop_front());
        end
      end
      if (bif.rsp1_valid) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          chk("rsp1_data", bif.rsp1_data, q1[0].data);
          chk("rsp1_ovf", bif.rsp1_ovf, q1[0].ovf);
          if (bif.rsp1_ready) void'(q1.pop_front());
        end
      end
    end
  end

  task automatic send(input int port, input logic [NB-1:0] d);
    exp_t e;
    bit   done = 0;
    e.data = d + 1'b1;
    e.ovf  = (d == {NB{1'b1}});
    @(posedge clk); #1;
    if (port == 0) begin bif.req0_valid = 1'b1; bif.req0_data = d; end
    else           begin bif.req1_valid = 1'b1; bif.req1_data = d; end
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (port == 0 ? bif.req0_ready : bif.req1_ready) begin
        if (port == 0) q0.push_back(e); else q1.push_back(e);
        done = 1;
      end
    end
    if (!done) chk($sformatf("accept_timeout_port%0d", port), 0, 1);
    @(posedge clk); #1;
    if (port == 0) begin bif.req0_valid = 1'b0; bif.req0_data = NB'($urandom); end
    else           begin bif.req1_valid = 1'b0; bif.req1_data = NB'($urandom); end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !m_busy) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp0_valid"}, bif.rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, bif.rsp1_valid, 0);
    chk({tag, "_rsp0_data"}, bif.rsp0_data, 0);
    chk({tag, "_rsp1_data"}, bif.rsp1_data, 0);
    chk({tag, "_rsp_ovf"}, {bif.rsp1_ovf, bif.rsp0_ovf}, 0);
    chk({tag, "_add_reset"}, bif.add_reset, 0);
    chk({tag, "_add_in"}, bif.add_in, 0);
    chk({tag, "_req_ready"}, {bif.req1_ready, bif.req0_ready}, 0);
  endtask

  initial begin
    reset = 1'b1;
    bif.req0_valid = 1'b0; bif.req1_valid = 1'b0;
    bif.req0_data  = '0;   bif.req1_data  = '0;
    #3;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    send(0, 4'h5); drain();
    send(1, 4'hF); drain();

    // Ties after a fresh reset: req0 first, then alternate.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    fork send(0, 4'h3); send(1, 4'h9); join
    drain();
    fork send(0, 4'h1); send(1, 4'h2); join
    drain();

    // Stall the owner's response while the other requester waits.
    mode = 2; man0 = 1'b0;
    fork
      send(0, 4'h7);
      begin repeat (2) @(posedge clk); send(1, 4'h2); end
      begin
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (bif.rsp0_valid) seen = 1;
        end
        if (!seen) chk("stall_rsp0_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1 man0 = 1'b1;
      end
    join
    drain();
    mode = 0;

    // Abort in SHIFT with k=2.
    send(0, 4'hD);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("abort");
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", {bif.rsp1_valid, bif.rsp0_valid}, 0);
    send(0, 4'hB); drain();

    // Exhaustive sweep on both ports under random back-pressure.
    mode = 1;
    fork
      for (int v = 0; v < 16; v++) send(0, NB'(v));
      for (int v = 15; v >= 0; v--) send(1, NB'(v));
    join
    drain();
    mode = 0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/add1_seq_ctrl.md
# add1_seq_ctrl

Sequencer and two-port arbiter for the bit-serial incrementer datapath. It accepts parallel NUMBITS-wide operands from two requesters over valid/ready handshakes and grants the shared incrementer round-robin. For each operand it clears the incrementer, streams the bits LSB-first, and collects the serial result. It returns the incremented word plus an overflow flag to the requester that owns the operand.

## Interface
- NUMBITS, 4, operand/result width; legal range is 2 or more.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester i has an operand.
- req0_data / req1_data  in  NUMBITS  operand from requester i.
- req0_ready / req1_ready  out  1  controller accepts the operand from requester i this cycle.
- rsp0_valid / rsp1_valid  out  1  result for requester i is held on its rsp outputs.
- rsp0_ready / rsp1_ready  in  1  requester i takes its result.
- rsp0_data / rsp1_data  out  NUMBITS  result, equal to (operand + 1) mod 2^NUMBITS.
- rsp0_ovf / rsp1_ovf  out  1  set when the operand was all ones.
- add_reset  out  1  clear pulse to the incrementer.
- add_in  out  1  serial operand bit to the incrementer.
- add_out  in  1  serial result bit from the incrementer.

## Operation
- Incrementer contract:
  - An edge with add_reset=1 sets the carry to 1.
  - With add_reset low, add_out = add_in ^ carry, combinational within the cycle.
  - Each edge with add_reset low updates carry <= add_in & carry.
- FSM states: IDLE, CLR, SHIFT, RESP.
- IDLE: arbitration.
  - grant = the requester whose valid is high. If both are high, grant goes to the requester not in last_grant.
  - req_ready[grant] = 1 combinationally. It is never high outside IDLE, and never high for both requesters.
  - On an edge with valid & ready: latch the operand into op_reg, owner <= grant, last_grant <= grant, ovf_reg <= &operand, then go to CLR.
- CLR: drive add_reset=1 and add_in=0 for exactly one cycle, then go to SHIFT with bit index k=0.
- SHIFT: drive add_reset=0 and add_in=op_reg[k].
  - At the closing edge: res_reg[k] <= add_out, then k++.
  - After k=NUMBITS-1, go to RESP.
- RESP: assert rsp_valid[owner], with rsp_data[owner]=res_reg and rsp_ovf[owner]=ovf_reg. The non-owner's rsp_valid stays 0.
  - Valid, data and ovf are held stable until rsp_ready[owner] is high at an edge; then go to IDLE.
  - The non-owner cannot be accepted while the controller is busy.
- Arithmetic: bit k of the result is produced from bit k of the operand.
  - All-ones operand wraps to 0 with ovf=1.
  - All other operands give ovf=0.
- last_grant reset value is 1, so requester 0 wins the first tie after reset.

## Timing
- Reset values, applied immediately on reset assertion:
  - state=IDLE, k=0, last_grant=1.
  - req_ready follows IDLE arbitration (0 while no valid is high).
  - rsp*_valid=0, rsp*_data=0, rsp*_ovf=0.
  - add_reset=0, add_in=0, res_reg=0, op_reg=0.
- Latency, with E = the accept edge:
  - CLR occupies the cycle after E.
  - SHIFT occupies the next NUMBITS cycles.
  - rsp_valid rises right after edge E+NUMBITS+1 and is first sampled at edge E+NUMBITS+2.
- Throughput with rsp_ready held high: one operand per NUMBITS+3 cycles.
- rsp_ready low stalls RESP indefinitely with no change to any output.
- Reset mid-operation (any state): abort, drop the operand with no response, return to reset values. The next transaction re-clears the incrementer via CLR, so stale carry has no effect.
- A requester's valid may drop before it is granted; there is no obligation to accept it.
- Changes on req_data outside the accept edge are ignored.

## Test plan
- req0 sends 4'h5, rsp0_ready=1 -> rsp0_data=4'h6, ovf=0. rsp0_valid first sampled high at E+6, and add_reset high only in cycle E+1.
- req1 sends 4'hF -> rsp1_data=4'h0, rsp1_ovf=1. rsp0_valid stays 0 throughout.
- After reset, both valid, req0=4'h3 and req1=4'h9 held -> results in order rsp0=4'h4, then rsp1=4'hA. A following simultaneous pair is served req0 then req1 again, alternating per tie. Never both ready in the same cycle.
- req0 4'h7 with rsp0_ready low for 5 cycles after rsp0_valid rises, req1 valid meanwhile -> rsp0 holds 4'h8 stable, and req1_ready stays 0 until the cycle after rsp0 is taken.
- Assert reset during SHIFT at k=2 -> all outputs take reset values immediately and no response is issued. Next req0 4'hB -> 4'hC with correct timing.
- Exhaustive sweep 0..15 on each requester, with random rsp_ready back-pressure -> every result equals operand+1 mod 16, and ovf is set only for 15.
